// File: rtl/mac_accum_seq.sv
// Burst multiply-accumulate engine: accepts len_i operand pairs, accumulates x*y
// through a two-stage pipeline and returns one result with a single-cycle valid pulse.
module mac_accum_seq #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int LEN_W    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    output logic              ready_o,
    output logic              busy_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_valid_o,
    output logic              ovf_o
);

    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [LEN_W-1:0]    cnt_reg;
    logic [PROD_W-1:0]   prod_reg;
    logic                pvld_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic                ovf_acc_reg;
    logic [ACC_W-1:0]    result_reg;
    logic                result_valid_reg;
    logic                ovf_reg;
    logic [ACC_W:0]      sum_wide;
    logic                start_take;
    logic                beat_accept;
    logic                last_beat;

    assign start_take  = (state_reg == IDLE) && start_i;
    assign beat_accept = (state_reg == ACCUM) && valid_i;
    assign last_beat   = beat_accept && (cnt_reg == LEN_W'(1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (last_beat) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (start_take) begin
            cnt_reg <= len_i;
        end else if (beat_accept) begin
            cnt_reg <= cnt_reg - LEN_W'(1);
        end
    end

    // Stage 1: register the product of each accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_reg <= '0;
            pvld_reg <= 1'b0;
        end else begin
            pvld_reg <= beat_accept;
            if (beat_accept) begin
                prod_reg <= x_i * y_i;
            end
        end
    end

    // Stage 2: one extra bit catches the carry out of the accumulator.
    assign sum_wide = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(prod_reg);

    generate
        if (SATURATE) begin : g_sat
            // All-ones is sticky: any further add either overflows again or adds zero.
            assign acc_next = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        end else begin : g_wrap
            assign acc_next = sum_wide[ACC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_reg     <= '0;
            ovf_acc_reg <= 1'b0;
        end else if (start_take) begin
            acc_reg     <= '0;
            ovf_acc_reg <= 1'b0;
        end else if (pvld_reg) begin
            acc_reg <= acc_next;
            if (sum_wide[ACC_W]) begin
                ovf_acc_reg <= 1'b1;
            end
        end
    end

    // Result is published on leaving DONE, so the pulse lands in the following IDLE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_reg       <= '0;
            ovf_reg          <= 1'b0;
            result_valid_reg <= 1'b0;
        end else begin
            result_valid_reg <= (state_reg == DONE);
            if (state_reg == DONE) begin
                result_reg <= acc_reg;
                ovf_reg    <= ovf_acc_reg;
            end
        end
    end

    assign ready_o        = (state_reg == ACCUM);
    assign busy_o         = (state_reg != IDLE);
    assign result_o       = result_reg;
    assign result_valid_o = result_valid_reg;
    assign ovf_o          = ovf_reg;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench for mac_accum_seq: a saturating and a wrapping instance share one
// stimulus stream and are checked against hand-computed results.
module tb_mac_accum_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rstn;
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic              valid_i;
    logic [DATA_W-1:0] x_i;
    logic [DATA_W-1:0] y_i;

    logic              ready_s, busy_s, rv_s, ovf_s;
    logic [ACC_W-1:0]  result_s;
    logic              ready_w, busy_w, rv_w, ovf_w;
    logic [ACC_W-1:0]  result_w;

    int checks;
    int failures;

    mac_accum_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i),
        .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
        .ready_o(ready_s), .busy_o(busy_s), .result_o(result_s),
        .result_valid_o(rv_s), .ovf_o(ovf_s)
    );

    mac_accum_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i),
        .valid_i(valid_i), .x_i(x_i), .y_i(y_i),
        .ready_o(ready_w), .busy_o(busy_w), .result_o(result_w),
        .result_valid_o(rv_w), .ovf_o(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int len);
        start_i = 1'b1;
        len_i   = LEN_W'(len);
        tick();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic beat(input int x, input int y);
        valid_i = 1'b1;
        x_i     = DATA_W'(x);
        y_i     = DATA_W'(y);
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b1;
        start_i  = 1'b0;
        len_i    = '0;
        valid_i  = 1'b0;
        x_i      = '0;
        y_i      = '0;

        // Reset state
        #1 rstn = 1'b0;
        #2;
        check("rst_busy",   {31'd0, busy_s},  0);
        check("rst_ready",  {31'd0, ready_s}, 0);
        check("rst_rv",     {31'd0, rv_s},    0);
        check("rst_result", {16'd0, result_s}, 0);
        check("rst_ovf",    {31'd0, ovf_s},   0);
        #10 rstn = 1'b1;
        tick();

        // T1: four (3,4) beats back-to-back -> 48, pulse in the cycle after E+2
        start_burst(4);
        check("t1_busy",  {31'd0, busy_s},  1);
        check("t1_ready", {31'd0, ready_s}, 1);
        for (int i = 0; i < 4; i++) beat(3, 4);
        check("t1_ready_drop", {31'd0, ready_s}, 0);
        check("t1_rv_e0",      {31'd0, rv_s},    0);
        tick();
        check("t1_rv_e1",      {31'd0, rv_s},    0);
        check("t1_busy_done",  {31'd0, busy_s},  1);
        tick();
        check("t1_rv_e2",      {31'd0, rv_s},    1);
        check("t1_result",     {16'd0, result_s}, 48);
        check("t1_result_w",   {16'd0, result_w}, 48);
        check("t1_ovf",        {31'd0, ovf_s},   0);
        check("t1_busy_idle",  {31'd0, busy_s},  0);
        tick();
        check("t1_rv_pulse",   {31'd0, rv_s},    0);
        check("t1_result_hold", {16'd0, result_s}, 48);

        // T2: (255,255) twice overflows 16 bits
        start_burst(2);
        beat(255, 255);
        beat(255, 255);
        tick();
        tick();
        check("t2_rv",       {31'd0, rv_s},    1);
        check("t2_rv_w",     {31'd0, rv_w},    1);
        check("t2_result_s", {16'd0, result_s}, 32'h0000FFFF);
        check("t2_ovf_s",    {31'd0, ovf_s},   1);
        check("t2_result_w", {16'd0, result_w}, 32'h0000FC02);
        check("t2_ovf_w",    {31'd0, ovf_w},   1);

        // T3: started in the pulse cycle; gaps in valid_i stall only the count
        start_burst(3);
        check("t3_b2b_busy", {31'd0, busy_s}, 1);
        beat(2, 5);
        tick();
        tick();
        beat(1, 1);
        check("t3_ready_mid", {31'd0, ready_s}, 1);
        tick();
        beat(10, 10);
        check("t3_ready_drop", {31'd0, ready_s}, 0);
        tick();
        tick();
        check("t3_rv",       {31'd0, rv_s},    1);
        check("t3_result",   {16'd0, result_s}, 111);
        check("t3_result_w", {16'd0, result_w}, 111);
        check("t3_ovf",      {31'd0, ovf_s},   0);
        tick();

        // T4: zero-length burst
        start_burst(0);
        check("t4_rv_c1",   {31'd0, rv_s},    0);
        check("t4_busy_c1", {31'd0, busy_s},  1);
        check("t4_ready",   {31'd0, ready_s}, 0);
        tick();
        check("t4_rv",      {31'd0, rv_s},    1);
        check("t4_result",  {16'd0, result_s}, 0);
        check("t4_ovf",     {31'd0, ovf_s},   0);
        check("t4_busy",    {31'd0, busy_s},  0);
        tick();

        // T5: start_i during ACCUM is ignored
        start_burst(3);
        beat(1, 2);
        start_i = 1'b1;
        len_i   = 8'd9;
        beat(3, 4);
        start_i = 1'b0;
        len_i   = '0;
        check("t5_ready_mid", {31'd0, ready_s}, 1);
        beat(5, 6);
        check("t5_ready_drop", {31'd0, ready_s}, 0);
        tick();
        tick();
        check("t5_rv",     {31'd0, rv_s},    1);
        check("t5_result", {16'd0, result_s}, 44);
        tick();
        check("t5_busy_after", {31'd0, busy_s}, 0);

        // T6: asynchronous reset mid-burst, then a fresh one-beat burst
        start_burst(5);
        beat(1, 1);
        beat(2, 2);
        #2 rstn = 1'b0;
        #1;
        check("t6_busy",   {31'd0, busy_s},  0);
        check("t6_ready",  {31'd0, ready_s}, 0);
        check("t6_rv",     {31'd0, rv_s},    0);
        check("t6_result", {16'd0, result_s}, 0);
        check("t6_ovf",    {31'd0, ovf_s},   0);
        #3 rstn = 1'b1;
        tick();
        start_burst(1);
        beat(7, 7);
        tick();
        tick();
        check("t6_rv_new",     {31'd0, rv_s},    1);
        check("t6_result_new", {16'd0, result_s}, 49);
        check("t6_ovf_new",    {31'd0, ovf_s},   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
